// File: rtl/render_pkg.sv
// render_pkg: shared FSM/object types, box geometry and colours for object_renderer
package render_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, FINISH} state_e;
  typedef enum logic [1:0] {PLANE, LAVA, MTN1, MTN2} obj_e;
  localparam int PLANE_W = 16;
  localparam int PLANE_H = 8;
  localparam int LAVA_W = 8;
  localparam int LAVA_H = 8;
  localparam int MTN_W = 16;
  localparam int MTN_H = 32;
  localparam logic [2:0] COL_BG = 3'b000;
  localparam logic [2:0] COL_PLANE = 3'b111;
  localparam logic [2:0] COL_LAVA = 3'b100;
  localparam logic [2:0] COL_MOUNTAIN = 3'b010;
  function automatic logic [4:0] obj_wm1(obj_e o);
    return o == PLANE ? 5'(PLANE_W - 1) : o == LAVA ? 5'(LAVA_W - 1) : 5'(MTN_W - 1);
  endfunction
  function automatic logic [4:0] obj_hm1(obj_e o);
    return o == PLANE ? 5'(PLANE_H - 1) : o == LAVA ? 5'(LAVA_H - 1) : 5'(MTN_H - 1);
  endfunction
  function automatic logic [2:0] obj_colour(obj_e o);
    return o == PLANE ? COL_PLANE : o == LAVA ? COL_LAVA : COL_MOUNTAIN;
  endfunction
endpackage

// File: rtl/object_renderer_if.sv
// object_renderer_if: pixel write port between the renderer and the VGA adapter
interface object_renderer_if;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] colour;
  logic plot;
  logic pix_ready;
  modport master (output vga_x, vga_y, colour, plot, input pix_ready);
  modport slave (input vga_x, vga_y, colour, plot, output pix_ready);
endinterface

// File: rtl/object_renderer_box_scanner.sv
// box_scanner: row-major walk over one box with screen clipping and a registered plot/ready pixel port
module box_scanner #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  input  logic [4:0] wm1,
  input  logic [4:0] hm1,
  input  logic [2:0] col,
  input  logic       pix_ready,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       last
);
  logic active, adv, row_end;
  logic [9:0] ox, oy;
  logic [4:0] w, h, dx, dy, ndx, ndy;
  logic [10:0] px, py;
  // clipped pixels have plot=0 and so advance without waiting for ready
  assign adv = active && (!plot || pix_ready);
  assign row_end = dx == w;
  assign last = adv && row_end && dy == h;
  assign ndx = start || row_end ? 5'd0 : dx + 5'd1;
  assign ndy = start ? 5'd0 : row_end ? dy + 5'd1 : dy;
  assign px = {1'b0, start ? org_x : ox} + {6'd0, ndx};
  assign py = {1'b0, start ? org_y : oy} + {6'd0, ndy};
  always_ff @(posedge clk)
    if (reset) begin
      active <= 1'b0;
      ox <= '0;
      oy <= '0;
      w <= '0;
      h <= '0;
      dx <= '0;
      dy <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
    end else if (start || adv) begin
      if (start) begin
        ox <= org_x;
        oy <= org_y;
        w <= wm1;
        h <= hm1;
        colour <= col;
      end
      active <= start || !last;
      dx <= ndx;
      dy <= ndy;
      x <= px[9:0];
      y <= py[8:0];
      plot <= (start || !last) && px < 11'(SCREEN_W) && py < 11'(SCREEN_H);
    end
endmodule

// File: rtl/object_renderer.sv
// object_renderer: per-frame erase/draw of plane, lava drop and two mountains as a VGA pixel stream
// Build option RENDER_ERASE_EN adds the erase pass and previous-position storage.
module object_renderer
  import render_pkg::*;
#(
  parameter int PLANE_X = 40,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic [9:0] plane_y,
  input  logic [9:0] lava_x,
  input  logic [9:0] lava_y,
  input  logic [9:0] mountain1_x,
  input  logic [9:0] mountain1_y,
  input  logic [9:0] mountain2_x,
  input  logic [9:0] mountain2_y,
  object_renderer_if.master vga,
  output logic       busy,
  output logic       done
);
  state_e state, state_n;
  obj_e obj, obj_n, nxt_obj, erase_obj;
  logic start, last, nxt_erase, erase_go;
  logic [9:0] erase_x, erase_y, draw_x, draw_y;
  logic [9:0] live_x [4], live_y [4], snap_x [4], snap_y [4];
  assign live_x = '{10'(PLANE_X), lava_x, mountain1_x, mountain2_x};
  assign live_y = '{plane_y, lava_y, mountain1_y, mountain2_y};
  // the first box starts while LATCH is still loading, so it reads the live inputs
  assign draw_x = state == LATCH ? live_x[nxt_obj] : snap_x[nxt_obj];
  assign draw_y = state == LATCH ? live_y[nxt_obj] : snap_y[nxt_obj];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      obj <= PLANE;
    end else begin
      state <= state_n;
      obj <= obj_n;
    end
  always_ff @(posedge clk)
    if (state == LATCH) begin
      snap_x <= live_x;
      snap_y <= live_y;
    end
`ifdef RENDER_ERASE_EN
  logic [9:0] prev_x [4], prev_y [4];
  logic [3:0] prev_valid;
  logic [2:0] search_from;
  always_ff @(posedge clk)
    if (reset) prev_valid <= '0;
    else if (state == DRAW && last) begin
      prev_valid[obj] <= 1'b1;
      prev_x[obj] <= snap_x[obj];
      prev_y[obj] <= snap_y[obj];
    end
  // next object with a stored box, searching from the one after the current erase
  always_comb begin
    search_from = state == ERASE ? {1'b0, obj} + 3'd1 : 3'd0;
    erase_go = 1'b0;
    erase_obj = PLANE;
    for (int i = 3; i >= 0; i--)
      if (prev_valid[2'(i)] && i >= int'(search_from)) begin
        erase_go = 1'b1;
        erase_obj = obj_e'(2'(i));
      end
  end
  assign erase_x = prev_x[erase_obj];
  assign erase_y = prev_y[erase_obj];
`else
  assign erase_go = 1'b0;
  assign erase_obj = PLANE;
  assign erase_x = '0;
  assign erase_y = '0;
`endif
  always_comb begin
    state_n = state;
    obj_n = obj;
    start = 1'b0;
    nxt_erase = 1'b0;
    nxt_obj = PLANE;
    case (state)
      IDLE: state_n = frame_start ? LATCH : IDLE;
      LATCH, ERASE:
        if (state == LATCH || last) begin
          start = 1'b1;
          nxt_erase = erase_go;
          nxt_obj = erase_go ? erase_obj : PLANE;
          state_n = erase_go ? ERASE : DRAW;
          obj_n = nxt_obj;
        end
      DRAW:
        if (last) begin
          start = obj != MTN2;
          nxt_obj = obj_e'(obj + 2'd1);
          state_n = obj == MTN2 ? FINISH : DRAW;
          obj_n = nxt_obj;
        end
      default: state_n = IDLE;
    endcase
  end
  box_scanner #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) scan (
    .clk,
    .reset,
    .start,
    .org_x(nxt_erase ? erase_x : draw_x),
    .org_y(nxt_erase ? erase_y : draw_y),
    .wm1(obj_wm1(nxt_obj)),
    .hm1(obj_hm1(nxt_obj)),
    .col(nxt_erase ? COL_BG : obj_colour(nxt_obj)),
    .pix_ready(vga.pix_ready),
    .x(vga.vga_x),
    .y(vga.vga_y),
    .colour(vga.colour),
    .plot(vga.plot),
    .last
  );
  assign busy = state != IDLE;
  assign done = state == FINISH;
endmodule

// File: tb/tb_object_renderer.sv
// tb_object_renderer: table-driven frame checks against a pixel-stream model plus reset/frame_start corner cases
module tb_object_renderer;
`ifdef RENDER_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif
  typedef struct packed {logic [9:0] x; logic [8:0] y; logic [2:0] c;} pix_t;
  typedef struct {
    int py, lx, ly, m1x, m1y, m2x, m2y, stall;
    int done_n, plots_n, done_e, plots_e, bg_e, f128_e;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, busy, done;
  logic [9:0] plane_y = '0, lava_x = '0, lava_y = '0;
  logic [9:0] mountain1_x = '0, mountain1_y = '0, mountain2_x = '0, mountain2_y = '0;
  int checks = 0, failures = 0;
  int done_cyc, first_cyc, hold_bad, busy1;
  pix_t first_pix;
  pix_t got_q[$], exp_q[$];
  int m_x[4], m_y[4];
  bit m_have = 1'b0;
  vec_t tbl[5];
  object_renderer_if vga();
  object_renderer dut (
    .clk, .reset, .frame_start, .plane_y, .lava_x, .lava_y,
    .mountain1_x, .mountain1_y, .mountain2_x, .mountain2_y,
    .vga(vga), .busy, .done
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic pix_t cur();
    pix_t p;
    p.x = vga.vga_x;
    p.y = vga.vga_y;
    p.c = vga.colour;
    return p;
  endfunction
  task automatic add_box(input int ox, input int oy, input int w, input int h, input logic [2:0] c);
    pix_t p;
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        if (ox + dx < 640 && oy + dy < 480) begin
          p.x = 10'(ox + dx);
          p.y = 9'(oy + dy);
          p.c = c;
          exp_q.push_back(p);
        end
  endtask
  task automatic model_frame(input vec_t v);
    int cx[4], cy[4], bw[4], bh[4];
    logic [2:0] col[4];
    cx = '{40, v.lx, v.m1x, v.m2x};
    cy = '{v.py, v.ly, v.m1y, v.m2y};
    bw = '{16, 8, 16, 16};
    bh = '{8, 8, 32, 32};
    col = '{3'b111, 3'b100, 3'b010, 3'b010};
    exp_q.delete();
    if (ERASE_EN && m_have)
      for (int i = 0; i < 4; i++) add_box(m_x[i], m_y[i], bw[i], bh[i], 3'b000);
    for (int i = 0; i < 4; i++) add_box(cx[i], cy[i], bw[i], bh[i], col[i]);
    m_x = cx;
    m_y = cy;
    m_have = 1'b1;
  endtask
  task automatic apply(input vec_t v);
    plane_y = 10'(v.py);
    lava_x = 10'(v.lx);
    lava_y = 10'(v.ly);
    mountain1_x = 10'(v.m1x);
    mountain1_y = 10'(v.m1y);
    mountain2_x = 10'(v.m2x);
    mountain2_y = 10'(v.m2y);
  endtask
  // drives one frame; ready is low on clipped cycles and for 3 cycles at pixel index stall_at
  task automatic run_frame(input int stall_at, input int pulse_at);
    int cyc = 1, left = 0;
    bit stalled = 1'b0;
    pix_t h = '0;
    got_q.delete();
    done_cyc = -1;
    first_cyc = -1;
    hold_bad = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    busy1 = int'(busy);
    while (cyc < 6000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      frame_start = cyc == pulse_at;
      if (vga.plot) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_pix = cur();
        end
        if (!stalled && got_q.size() == stall_at) begin
          stalled = 1'b1;
          left = 3;
          h = cur();
        end
        if (left > 0) begin
          left--;
          vga.pix_ready = 1'b0;
          if (cur() != h) hold_bad++;
        end else begin
          vga.pix_ready = 1'b1;
          got_q.push_back(cur());
        end
      end else vga.pix_ready = 1'b0;
      @(negedge clk);
      cyc++;
    end
    frame_start = 1'b0;
  endtask
  task automatic stream_check(input string name);
    int mism, n;
    mism = got_q.size() != exp_q.size() ? 1 : 0;
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) mism++;
    check(name, mism, 0);
  endtask
  function automatic int count_bg(input int upto);
    int n = 0;
    for (int i = 0; i < got_q.size() && i < upto; i++) if (got_q[i].c == 3'b000) n++;
    return n;
  endfunction
  initial begin
    int idle_bad;
    tbl[0] = '{50, 400, 50, 300, 150, 500, 150, -1, 1218, 1216, 1218, 1216, 0, 0};
    tbl[1] = '{58, 400, 50, 300, 150, 500, 150, -1, 1218, 1216, 2434, 2432, 1216, 128};
    tbl[2] = '{58, 400, 50, 300, 150, 500, 150, 9, 1221, 1216, 2437, 2432, 1216, 128};
    tbl[3] = '{58, 400, 476, 300, 150, 630, 150, -1, 1218, 992, 2434, 2208, 1216, 128};
    tbl[4] = '{58, 400, 476, 300, 150, 630, 150, -1, 1218, 992, 2434, 1984, 992, 128};
    vga.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({vga.vga_x, vga.vga_y, vga.colour, vga.plot, busy, done}), 0);
    reset = 1'b0;
    for (int f = 0; f < 5; f++) begin
      apply(tbl[f]);
      model_frame(tbl[f]);
      run_frame(tbl[f].stall, -1);
      check($sformatf("f%0d_done", f), done_cyc, ERASE_EN ? tbl[f].done_e : tbl[f].done_n);
      check($sformatf("f%0d_plots", f), got_q.size(), ERASE_EN ? tbl[f].plots_e : tbl[f].plots_n);
      check($sformatf("f%0d_bg", f), count_bg(99999), ERASE_EN ? tbl[f].bg_e : 0);
      check($sformatf("f%0d_bg_first128", f), count_bg(128), ERASE_EN ? tbl[f].f128_e : 0);
      check($sformatf("f%0d_busy_latch", f), busy1, 1);
      stream_check($sformatf("f%0d_stream", f));
      if (f == 0) begin
        check("f0_first_cycle", first_cyc, 2);
        check("f0_first_pixel", int'(first_pix), int'({10'd40, 9'd50, 3'd7}));
      end
      if (tbl[f].stall >= 0) check($sformatf("f%0d_stall_hold", f), hold_bad, 0);
    end
    apply(tbl[0]);
    vga.pix_ready = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (ERASE_EN ? 1500 : 300) @(negedge clk);
    check("mid_draw_plot", int'(vga.plot), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", int'({vga.vga_x, vga.vga_y, vga.colour, vga.plot, busy, done}), 0);
    reset = 1'b0;
    m_have = 1'b0;
    model_frame(tbl[0]);
    run_frame(-1, -1);
    check("post_reset_done", done_cyc, 1218);
    check("post_reset_bg", count_bg(99999), 0);
    stream_check("post_reset_stream");
    model_frame(tbl[0]);
    run_frame(-1, 100);
    check("ignore_busy_done", done_cyc, ERASE_EN ? 2434 : 1218);
    stream_check("ignore_busy_stream");
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    idle_bad = 0;
    repeat (6) begin
      if (busy || vga.plot) idle_bad++;
      @(negedge clk);
    end
    check("ignore_on_done_idle", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
